snake_step_ctrl: RTL and testbench



---
 rtl/snake_pkg.sv | 24 ++
 rtl/turn_fifo.sv | 55 +++++
 rtl/snake_step_ctrl.sv | 96 +++++++++
 tb/tb_snake_step_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types for the snake game: modes, headings, relative turns.
package snake_pkg;

  typedef enum logic [1:0] {MENU, GAME, PAUSE, OVER} game_mode;
  typedef enum logic [1:0] {UP, RIGHT, DOWN, LEFT} direction;
  typedef enum logic {TURN_L, TURN_R} turn_t;

  localparam int unsigned STEP_CYCLES_DEFAULT = 25_000_000;

  // Relative turn; never yields a reversal.
  function automatic direction turn_dir(input direction d, input turn_t t);
    direction r;
    r = d;
    case (d)
      UP:      r = (t == TURN_L) ? LEFT  : RIGHT;
      DOWN:    r = (t == TURN_L) ? RIGHT : LEFT;
      LEFT:    r = (t == TURN_L) ? DOWN  : UP;
      RIGHT:   r = (t == TURN_L) ? UP    : DOWN;
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/turn_fifo.sv
// Circular buffer of turn commands; push and pop may share an edge, even when full.
module turn_fifo
  import snake_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  turn_t                      din,
  input  logic                       pop,
  output turn_t                      dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  turn_t           mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_next(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
      if (do_push && !do_pop)      count_q <= count_q + CntW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/snake_step_ctrl.sv
// Step scheduler: queues click turns, paces steps with a timer, hands heading
// to the board engine over req/ack.
module snake_step_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = STEP_CYCLES_DEFAULT,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  game_mode                         mode,
  input  logic                             left,
  input  logic                             right,
  input  logic                             step_ack,
  output direction                         dir,
  output logic                             step_req,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] queue_count,
  output logic                             drop
);

  localparam int unsigned TimerW = $clog2(STEP_CYCLES);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StReq} state_e;

  state_e            state_q;
  logic [TimerW-1:0] timer_q;
  logic              left_q, right_q;
  logic              click_l, click_r, in_game;
  logic              push, pop, fifo_full, fifo_empty;
  turn_t             push_turn, head;

  // History tracks the buttons unconditionally so a held button never reads as a click.
  always_ff @(posedge clk) begin
    left_q  <= left;
    right_q <= right;
  end

  assign click_l   = left & ~left_q;
  assign click_r   = right & ~right_q;
  assign in_game   = (mode == GAME);
  assign push_turn = click_r ? TURN_R : TURN_L;
  assign push      = in_game && (state_q != StIdle) && (click_l ^ click_r);
  assign pop       = in_game && (state_q == StRun) && (timer_q == TimerLast) && !fifo_empty;

  turn_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (!in_game),
    .push  (push),
    .din   (push_turn),
    .pop   (pop),
    .dout  (head),
    .count (queue_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst || !in_game) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      dir      <= UP;
      step_req <= 1'b0;
      drop     <= 1'b0;
    end else begin
      drop <= push && fifo_full && !pop;
      unique case (state_q)
        StIdle: begin
          timer_q <= '0;
          state_q <= StRun;
        end
        StRun: begin
          if (timer_q == TimerLast) begin
            timer_q  <= '0;
            state_q  <= StReq;
            step_req <= 1'b1;
            if (pop) dir <= turn_dir(dir, head);
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end
        StReq: begin
          if (step_ack) begin
            step_req <= 1'b0;
            state_q  <= StRun;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_step_ctrl.sv
// Directed and random stimulus against a queue-based reference of the step scheduler.
module tb_snake_step_ctrl;
  import snake_pkg::*;

  localparam int unsigned STEP  = 4;
  localparam int unsigned DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst, left, right, step_ack;
  game_mode   mode;
  direction   dir;
  logic       step_req, drop;
  logic [1:0] queue_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state
  bit       m_on, m_req, m_drop;
  direction m_dir;
  int       m_elapsed;
  turn_t    m_q[$];
  logic     m_lprv, m_rprv;

  always #5 clk = ~clk;

  snake_step_ctrl #(
    .STEP_CYCLES (STEP),
    .QUEUE_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .left        (left),
    .right       (right),
    .step_ack    (step_ack),
    .dir         (dir),
    .step_req    (step_req),
    .queue_count (queue_count),
    .drop        (drop)
  );

  // Headings in clockwise order: right turn = +1, left turn = -1.
  function automatic direction ref_turn(input direction d, input turn_t t);
    direction ring[4];
    int idx;
    ring[0] = UP; ring[1] = RIGHT; ring[2] = DOWN; ring[3] = LEFT;
    idx = 0;
    for (int i = 0; i < 4; i++) if (ring[i] == d) idx = i;
    idx = (t == TURN_R) ? (idx + 1) % 4 : (idx + 3) % 4;
    return ring[idx];
  endfunction

  task automatic model_edge();
    logic cl, cr;
    cl = left & ~m_lprv;
    cr = right & ~m_rprv;
    m_lprv = left;
    m_rprv = right;
    if (rst || mode != GAME) begin
      m_on = 0; m_req = 0; m_drop = 0; m_dir = UP; m_elapsed = 0;
      m_q.delete();
    end else if (!m_on) begin
      m_on = 1; m_elapsed = 0; m_drop = 0;
    end else begin
      m_drop = 0;
      if (!m_req) begin
        if (m_elapsed == STEP - 1) begin
          m_req = 1;
          m_elapsed = 0;
          if (m_q.size() > 0) m_dir = ref_turn(m_dir, m_q.pop_front());
        end else begin
          m_elapsed++;
        end
      end else if (step_ack) begin
        m_req = 0;
      end
      if (cl ^ cr) begin
        if (m_q.size() < DEPTH) m_q.push_back(cr ? TURN_R : TURN_L);
        else m_drop = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("dir", 32'(dir), 32'(m_dir));
    chk("step_req", 32'(step_req), 32'(m_req));
    chk("queue_count", 32'(queue_count), 32'(m_q.size()));
    chk("drop", 32'(drop), 32'(m_drop));
  endtask

  task automatic wait_req();
    for (int i = 0; i < 40 && step_req !== 1'b1; i++) tick();
    chk("wait_req_timeout", 32'(step_req), 32'd1);
  endtask

  task automatic pulse_left();
    left = 1'b1; tick(); left = 1'b0; tick();
  endtask

  initial begin
    rst = 1'b1; mode = GAME; left = 1'b0; right = 1'b0; step_ack = 1'b1;
    m_on = 0; m_req = 0; m_drop = 0; m_dir = UP; m_elapsed = 0;
    m_lprv = 1'b0; m_rprv = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (15) tick();

    // Single left turn, then a right turn back to UP.
    left = 1'b1; tick(); left = 1'b0; repeat (8) tick();
    right = 1'b1; tick(); right = 1'b0; repeat (8) tick();

    // Three clicks two cycles apart starting on a pop edge: third one overflows.
    for (int i = 0; i < 20 && !(m_on && !m_req && m_elapsed == STEP - 1); i++) tick();
    repeat (3) pulse_left();
    repeat (20) tick();

    // Simultaneous rising edges are ignored.
    left = 1'b1; right = 1'b1; tick();
    left = 1'b0; right = 1'b0; repeat (6) tick();

    // Stalled acknowledge.
    step_ack = 1'b0;
    wait_req();
    repeat (10) tick();
    step_ack = 1'b1;
    repeat (12) tick();

    // Leave GAME mid-handshake with turns queued.
    step_ack = 1'b0;
    wait_req();
    pulse_left();
    pulse_left();
    mode = MENU; tick();
    mode = GAME; step_ack = 1'b1;
    repeat (10) tick();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      left     = ($urandom_range(3) == 0);
      right    = ($urandom_range(3) == 0);
      step_ack = ($urandom_range(2) != 0);
      mode     = ($urandom_range(49) == 0) ? PAUSE : GAME;
      rst      = ($urandom_range(79) == 0);
      tick();
    end
    rst = 1'b0; mode = GAME;
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
